conv_channel_group_acc: RTL

Downstream neighbour of the 16-input-channel adder tree. Takes the tree's per-picture reduced sums, realigns a valid strobe through the tree's fixed latency, and accumulates successive 16-channel groups into one full-depth partial sum per output pixel. It emits one result word per output pixel and a done pulse at end of frame, feeding the bias/quantization stage.

---
 rtl/conv_channel_group_acc_pkg.sv | 15 +
 rtl/conv_channel_group_acc_valid_delay_line.sv | 27 ++
 rtl/conv_channel_group_acc.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/conv_channel_group_acc_pkg.sv
// Shared sizing for the adder-tree consumers.
// The bias stage imports the same widths, so lanes line up.
package conv_channel_group_acc_pkg;

  localparam int PICTURE_NUM    = 4;
  localparam int WIDTH_DATA_OUT = 8;
  localparam int LANE_W         = 2 * WIDTH_DATA_OUT;

  typedef logic [LANE_W-1:0] lane_t;

  function automatic int acc_width(input int guard);
    return LANE_W + guard;
  endfunction

endpackage

// File: rtl/conv_channel_group_acc_valid_delay_line.sv
// Fixed-depth strobe delay, used to follow a pipelined datapath.
// It shifts every cycle; only reset clears it.
module valid_delay_line #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  always_comb begin
    sr_d    = sr_q << 1;
    sr_d[0] = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/conv_channel_group_acc.sv
// Accumulates 16-channel groups from the adder tree into one
// full-depth partial sum per output pixel, lane-parallel.
module conv_channel_group_acc
  import conv_channel_group_acc_pkg::*;
#(
  parameter int TREE_LATENCY    = 4,
  parameter int ACC_GUARD       = 8,
  parameter int GROUP_CNT_WIDTH = 8,
  parameter int PIX_CNT_WIDTH   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [GROUP_CNT_WIDTH-1:0] group_num,
  input  logic [PIX_CNT_WIDTH-1:0] pix_num,
  input  logic tree_valid_in,
  input  logic [PICTURE_NUM*LANE_W-1:0] data_in,
  output logic [PICTURE_NUM*(LANE_W+ACC_GUARD)-1:0] data_out,
  output logic data_out_valid,
  output logic frame_done,
  output logic busy
);

  localparam int AW = acc_width(ACC_GUARD);
  localparam int LW = LANE_W;
  localparam int DW = PICTURE_NUM * AW;
  localparam int GW = GROUP_CNT_WIDTH;
  localparam int PW = PIX_CNT_WIDTH;
  localparam int FW = $clog2(TREE_LATENCY + 1);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_ACC  = 1'b1;

  localparam logic [FW-1:0] FLUSH_INIT = FW'(TREE_LATENCY);

  logic          state_q, state_d;
  logic [GW-1:0] g_q, g_d, gnum_q, gnum_d;
  logic [PW-1:0] p_q, p_d, pnum_q, pnum_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [DW-1:0] acc_q, acc_d, acc_nxt;
  logic [DW-1:0] dout_q, dout_d;
  logic          dval_q, dval_d;
  logic          done_q, done_d;

  logic          acc_en;
  logic          grp_en;
  logic          last_g;
  logic          last_p;
  logic [GW-1:0] g_max;
  logic [PW-1:0] p_max;

  valid_delay_line #(
    .DEPTH(TREE_LATENCY)
  ) u_vdl (
    .clk (clk),
    .rst (rst),
    .din (tree_valid_in),
    .dout(acc_en)
  );

  for (genvar l = 0; l < PICTURE_NUM; l++) begin : g_lane
    logic [LW-1:0] lane;
    logic [AW-1:0] ext;
    logic [AW-1:0] base;
    assign lane = data_in[l*LW +: LW];
    assign ext  = {{(AW-LW){lane[LW-1]}}, lane};
    assign base = (g_q == '0) ? '0 : acc_q[l*AW +: AW];
    assign acc_nxt[l*AW +: AW] = base + ext;
  end

  assign g_max = (gnum_q == '0) ? '0 : gnum_q - GW'(1);
  assign p_max = (pnum_q == '0) ? '0 : pnum_q - PW'(1);
  assign last_g = (g_q == g_max);
  assign last_p = (p_q == p_max);

  // Groups still in the tree at a restart must never reach the sum.
  assign grp_en = (state_q == S_ACC) && acc_en
               && (flush_q == '0);

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    gnum_d  = gnum_q;
    pnum_d  = pnum_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    dval_d  = 1'b0;
    done_d  = 1'b0;
    flush_d = (flush_q != '0) ? flush_q - FW'(1) : '0;
    if (start) begin
      state_d = S_ACC;
      g_d     = '0;
      p_d     = '0;
      gnum_d  = group_num;
      pnum_d  = pix_num;
      acc_d   = '0;
      flush_d = FLUSH_INIT;
    end else if (done_q) begin
      state_d = S_IDLE;
    end else if (grp_en) begin
      acc_d = acc_nxt;
      if (last_g) begin
        dout_d = acc_nxt;
        dval_d = 1'b1;
        g_d    = '0;
        if (last_p) begin
          done_d = 1'b1;
          p_d    = '0;
        end else begin
          p_d = p_q + PW'(1);
        end
      end else begin
        g_d = g_q + GW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      p_q     <= '0;
      gnum_q  <= '0;
      pnum_q  <= '0;
      flush_q <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      dval_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
      gnum_q  <= gnum_d;
      pnum_q  <= pnum_d;
      flush_q <= flush_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      dval_q  <= dval_d;
      done_q  <= done_d;
    end
  end

  assign data_out       = dout_q;
  assign data_out_valid = dval_q;
  assign frame_done     = done_q;
  assign busy           = (state_q == S_ACC);

endmodule
